state_enc: RTL and testbench

//  Forward (encryption) round sequencer for the AES datapath; companion of the decryption sequencer.

---
 rtl/state_enc_if.sv | 16 +
 rtl/state_enc.sv | 93 +++++++++
 tb/tb_state_enc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/state_enc_if.sv
// Host <-> forward round sequencer bundle: start/ack handshake in, state code,
// round counter and status decodes out.
interface state_enc_if;
  logic       start;
  logic       ack;
  logic [2:0] cs;
  logic [7:0] cot;
  logic       busy;
  logic       done;
  logic       last;

  // host side drives the handshake and watches the sequencer
  modport master (output start, ack, input cs, cot, busy, done, last);
  // sequencer side
  modport slave  (input start, ack, output cs, cot, busy, done, last);
endinterface

// File: rtl/state_enc.sv
// state_enc: AES forward (encryption) round sequencer.
// Emits the state code cs that the datapath decodes into AddRoundKey,
// SubBytes, ShiftRows, MixColumns and key-expansion steps. It also emits
// the round counter cot.
// Optional feature: define STATE_ENC_HOLD_EN to add a 'hold' stall input.
module state_enc #(
  parameter int NR = 10  // 10, 12 or 14 rounds
) (
  input  logic        clk,
  input  logic        res,
`ifdef STATE_ENC_HOLD_EN
  input  logic        hold,
`endif
  state_enc_if.slave  bus
);

  typedef enum logic [2:0] {
    IDL = 3'b000,
    STL = 3'b001,
    ADD = 3'b010,
    SUB = 3'b011,
    SHI = 3'b100,
    MIX = 3'b101,
    KEY = 3'b110,
    FIN = 3'b111
  } state_t;

  localparam logic [7:0] NR_C = 8'(NR);

  state_t     state_q, state_d;
  logic [7:0] cot_q,   cot_d;
  logic       stall;

`ifdef STATE_ENC_HOLD_EN
  // hold freezes the whole sequencer, including start sampling in IDL
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  // next-state and round-counter update; cot only advances on ADD->SUB
  always_comb begin
    state_d = state_q;
    cot_d   = cot_q;
    if (!stall) begin
      case (state_q)
        IDL: if (bus.start) begin
               state_d = STL;
               cot_d   = '0;
             end
        STL: state_d = ADD;
        ADD: if (cot_q == NR_C) begin
               state_d = FIN;
             end else begin
               state_d = SUB;
               cot_d   = cot_q + 8'd1;
             end
        SUB: state_d = SHI;
        // final round skips MixColumns
        SHI: state_d = (cot_q == NR_C) ? KEY : MIX;
        MIX: state_d = KEY;
        KEY: state_d = ADD;
        // ack beats a simultaneous start; start is re-sampled in IDL
        FIN: if (bus.ack) begin
               state_d = IDL;
               cot_d   = '0;
             end
        default: begin
          state_d = IDL;
          cot_d   = '0;
        end
      endcase
    end
  end

  // state and counter registers, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDL;
      cot_q   <= '0;
    end else begin
      state_q <= state_d;
      cot_q   <= cot_d;
    end
  end

  assign bus.cs   = state_q;
  assign bus.cot  = cot_q;
  assign bus.busy = (state_q != IDL) && (state_q != FIN);
  assign bus.done = (state_q == FIN);
  assign bus.last = (cot_q == NR_C);

endmodule

// File: tb/tb_state_enc.sv
// Bench for state_enc: NR=10 and NR=14 instances share one stimulus stream.
// A position-based reference model predicts each cycle's outputs into
// per-instance queues. A monitor pops those queues and compares them.
module tb_state_enc;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic start = 1'b0;
  logic ack = 1'b0;
`ifdef STATE_ENC_HOLD_EN
  logic hold = 1'b0;
`endif

  always #5 clk = ~clk;

  state_enc_if b10 ();
  state_enc_if b14 ();
  assign b10.start = start;
  assign b10.ack   = ack;
  assign b14.start = start;
  assign b14.ack   = ack;

  state_enc #(.NR(10)) u10 (
    .clk (clk),
    .res (res),
`ifdef STATE_ENC_HOLD_EN
    .hold(hold),
`endif
    .bus (b10)
  );

  state_enc #(.NR(14)) u14 (
    .clk (clk),
    .res (res),
`ifdef STATE_ENC_HOLD_EN
    .hold(hold),
`endif
    .bus (b14)
  );

  typedef struct packed {
    logic [2:0] cs;
    logic [7:0] cot;
    logic       busy;
    logic       done;
    logic       last;
  } obs_t;

  obs_t q10[$];
  obs_t q14[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   pos10  = -1;  // -1 = idle, otherwise steps since start was taken
  int   pos14  = -1;

  // Expected outputs at a given position within a run.
  // pos 0 = load, pos 1 = initial AddRoundKey, then five-step rounds and a
  // four-step final round; FIN sits at position 5*nr+1.
  function automatic obs_t expect_of(input int nr, input int pos);
    obs_t o;
    int q, k;
    o.cs  = 3'b000;
    o.cot = 8'd0;
    if (pos == 0) begin
      o.cs = 3'b001;
    end else if (pos == 1) begin
      o.cs = 3'b010;
    end else if (pos > 1) begin
      q = pos - 2;
      if (q < 5 * (nr - 1)) begin
        k     = q % 5;
        o.cot = 8'(q / 5 + 1);
        case (k)
          0:       o.cs = 3'b011;
          1:       o.cs = 3'b100;
          2:       o.cs = 3'b101;
          3:       o.cs = 3'b110;
          default: o.cs = 3'b010;
        endcase
      end else begin
        k     = q - 5 * (nr - 1);
        o.cot = 8'(nr);
        case (k)
          0:       o.cs = 3'b011;
          1:       o.cs = 3'b100;
          2:       o.cs = 3'b110;
          3:       o.cs = 3'b010;
          default: o.cs = 3'b111;
        endcase
      end
    end
    o.busy = (o.cs != 3'b000) && (o.cs != 3'b111);
    o.done = (o.cs == 3'b111);
    o.last = (o.cot == 8'(nr));
    return o;
  endfunction

  // One clock of the host-visible behaviour, from the handshake rules.
  function automatic int adv(input int nr, input int pos,
                             input logic r, input logic s, input logic a, input logic h);
    if (r)                return -1;
    if (h)                return pos;
    if (pos < 0)          return s ? 0 : -1;
    if (pos == 5*nr + 1)  return a ? -1 : pos;
    return pos + 1;
  endfunction

  // drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic r, input logic s, input logic a, input logic h);
    @(negedge clk);
    res   = r;
    start = s;
    ack   = a;
`ifdef STATE_ENC_HOLD_EN
    hold  = h;
`endif
    pos10 = adv(10, pos10, r, s, a, h);
    pos14 = adv(14, pos14, r, s, a, h);
    q10.push_back(expect_of(10, pos10));
    q14.push_back(expect_of(14, pos14));
  endtask

  task automatic chk(input string nm, input obs_t e, input obs_t g);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got cs=%b cot=%0d b/d/l=%b%b%b want cs=%b cot=%0d b/d/l=%b%b%b",
               nm, $time, g.cs, g.cot, g.busy, g.done, g.last,
               e.cs, e.cot, e.busy, e.done, e.last);
    end
  endtask

  // monitor: compare every presented output against the queued prediction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q10.size() > 0) chk("nr10", q10.pop_front(), {b10.cs, b10.cot, b10.busy, b10.done, b10.last});
      if (q14.size() > 0) chk("nr14", q14.pop_front(), {b14.cs, b14.cot, b14.busy, b14.done, b14.last});
    end
  end

  initial begin
    // reset for two cycles
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // full runs with start noise while busy, then a long FIN wait
    step(0, 1, 0, 0);
    repeat (80) step(0, 1'($urandom_range(0, 1)), 0, 0);
    repeat (20) step(0, 0, 0, 0);
    // ack and start together: ack wins, no same-cycle restart
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);

    // mid-run reset with the NR=10 instance at MIX, cot=5; ack noise ignored
    step(0, 1, 0, 0);
    repeat (24) step(0, 0, 1'($urandom_range(0, 1)), 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // fresh complete run afterwards
    step(0, 1, 0, 0);
    repeat (75) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

`ifdef STATE_ENC_HOLD_EN
    // stall three cycles at SUB, cot=4 on the NR=10 instance
    step(0, 1, 0, 0);
    repeat (17) step(0, 0, 0, 0);
    repeat (3)  step(0, 0, 0, 1);
    repeat (80) step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 0, 1, 0);
`endif

    // randomized traffic
    repeat (3000) begin
      step(($urandom_range(0, 255) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
`ifdef STATE_ENC_HOLD_EN
           ($urandom_range(0, 7) == 0)
`else
           1'b0
`endif
          );
    end

    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    #3;
    n_chk++;
    if (q10.size() != 0 || q14.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending10=%0d pending14=%0d want 0", q10.size(), q14.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
